// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset core.
// Holds the sequencing state enum, opcode/funct constants, the 3-bit ALU
// operation encoding, fault codes and small decode/ALU helper functions.
package mc_cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2a;

   // ALU operation encoding, identical to the one used by the existing ALU
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_ILLEGAL  = 2'b01;
   localparam logic [1:0] FAULT_MISALIGN = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

   localparam int REG_COUNT = 32;

   // Map an R-type funct field onto the ALU operation it needs
   function automatic logic [2:0] functToAluOp(input logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   // True when the op/funct pair belongs to the supported subset
   function automatic logic isLegal(input logic [5:0] op, input logic [5:0] funct);
      case (op)
         OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                          (funct == FN_OR)  || (funct == FN_SLT);
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // The single shared ALU; arithmetic wraps, slt compares signed
   function automatic logic [31:0] aluCompute(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file with two combinational read ports and one synchronous
// write port. r0 always reads zero and writes to it are dropped. All
// registers clear on synchronous reset.
// Ports: clk, reset, i_raddrA/i_raddrB -> o_rdataA/o_rdataB,
//        i_we/i_waddr/i_wdata write port.
module mc_regfile
   import mc_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  i_raddrA,
   input  logic [4:0]  i_raddrB,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdataA,
   output logic [31:0] o_rdataB
);

   logic [31:0] r_regs [REG_COUNT];

   // Storage update: reset clears every entry, otherwise write when enabled
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdataA = (i_raddrA == 5'd0) ? 32'd0 : r_regs[i_raddrA];
   assign o_rdataB = (i_raddrB == 5'd0) ? 32'd0 : r_regs[i_raddrB];

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle MIPS-subset core: one sequencing FSM and one shared ALU run each
// instruction over 3-5 states against a unified valid/ready memory port.
// Detects illegal instructions, misaligned data addresses and memory timeouts,
// all of which stop the core in a sticky HALT until reset.
// Ports: clk, reset (sync, active high); mem_req/mem_we/mem_addr/mem_wdata out,
//        mem_rdata/mem_ready in; retire pulse, pc_out, halted, fault[1:0].
module multicycle_processor
   import mc_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        retire,
   output logic [31:0] pc_out,
   output logic        halted,
   output logic [1:0]  fault
);

   localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

   stateT       r_state, w_nextState;
   logic [31:0] r_pc, r_ir, r_a, r_b, r_aluOut, r_mdr, r_waitCnt;
   logic [1:0]  r_fault, w_faultNext;

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_sext, w_rdA, w_rdB, w_aluA, w_aluB, w_aluY;
   logic [2:0]  w_aluOp;
   logic        w_memReq, w_memDone, w_timeoutHit, w_misaligned;

   assign w_op    = r_ir[31:26];
   assign w_rs    = r_ir[25:21];
   assign w_rt    = r_ir[20:16];
   assign w_rd    = r_ir[15:11];
   assign w_funct = r_ir[5:0];
   assign w_sext  = {{16{r_ir[15]}}, r_ir[15:0]};

   // Reset gates the request so an in-flight access is abandoned at once
   assign w_memReq     = !reset && ((r_state == S_FETCH) || (r_state == S_MEM));
   assign w_memDone    = w_memReq && mem_ready;
   assign w_timeoutHit = (TIMEOUT != 0) && w_memReq && !mem_ready && (r_waitCnt == TIMEOUT_M1);
   assign w_misaligned = (w_aluY[1:0] != 2'b00);

   mc_regfile uRegfile (
      .clk      (clk),
      .reset    (reset),
      .i_raddrA (w_rs),
      .i_raddrB (w_rt),
      .i_we     (r_state == S_WB),
      .i_waddr  ((w_op == OP_RTYPE) ? w_rd : w_rt),
      .i_wdata  ((w_op == OP_LW) ? r_mdr : r_aluOut),
      .o_rdataA (w_rdA),
      .o_rdataB (w_rdB)
   );

   // Shared ALU operand steering: PC+4 in FETCH, branch target in DECODE
   // (PC is already incremented there), the instruction's own operation in EXEC
   always_comb begin
      w_aluA  = r_pc;
      w_aluB  = 32'd4;
      w_aluOp = ALU_ADD;
      if (r_state == S_DECODE) begin
         w_aluB = {w_sext[29:0], 2'b00};
      end else if (r_state == S_EXEC) begin
         w_aluA = r_a;
         if (w_op == OP_RTYPE) begin
            w_aluB  = r_b;
            w_aluOp = functToAluOp(w_funct);
         end else if (w_op == OP_BEQ) begin
            w_aluB  = r_b;
            w_aluOp = ALU_SUB;
         end else begin
            w_aluB = w_sext;
         end
      end
   end
   assign w_aluY = aluCompute(w_aluOp, w_aluA, w_aluB);

   // Sequencing: next state and fault capture; every fault goes straight to HALT
   always_comb begin
      w_nextState = r_state;
      w_faultNext = r_fault;
      case (r_state)
         S_FETCH: begin
            if (w_memDone) begin
               w_nextState = S_DECODE;
            end else if (w_timeoutHit) begin
               w_nextState = S_HALT;
               w_faultNext = FAULT_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (isLegal(w_op, w_funct)) begin
               w_nextState = S_EXEC;
            end else begin
               w_nextState = S_HALT;
               w_faultNext = FAULT_ILLEGAL;
            end
         end
         S_EXEC: begin
            if ((w_op == OP_LW) || (w_op == OP_SW)) begin
               if (w_misaligned) begin
                  w_nextState = S_HALT;
                  w_faultNext = FAULT_MISALIGN;
               end else begin
                  w_nextState = S_MEM;
               end
            end else if ((w_op == OP_BEQ) || (w_op == OP_J)) begin
               w_nextState = S_FETCH;
            end else begin
               w_nextState = S_WB;
            end
         end
         S_MEM: begin
            if (w_memDone) begin
               w_nextState = (w_op == OP_SW) ? S_FETCH : S_WB;
            end else if (w_timeoutHit) begin
               w_nextState = S_HALT;
               w_faultNext = FAULT_TIMEOUT;
            end
         end
         S_WB:    w_nextState = S_FETCH;
         default: w_nextState = S_HALT;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath latches, PC and wait counter; the counter runs only while a
   // request is stalled, so it restarts from zero for every new request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_aluOut  <= '0;
         r_mdr     <= '0;
         r_fault   <= FAULT_NONE;
         r_waitCnt <= '0;
      end else begin
         r_fault   <= w_faultNext;
         r_waitCnt <= (w_memReq && !mem_ready) ? r_waitCnt + 32'd1 : 32'd0;
         case (r_state)
            S_FETCH: begin
               if (w_memDone) begin
                  r_ir <= mem_rdata;
                  r_pc <= w_aluY;
               end
            end
            S_DECODE: begin
               r_a      <= w_rdA;
               r_b      <= w_rdB;
               r_aluOut <= w_aluY;
            end
            S_EXEC: begin
               if (w_op == OP_BEQ) begin
                  if (w_aluY == 32'd0) r_pc <= r_aluOut;
               end else if (w_op == OP_J) begin
                  r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
               end else begin
                  r_aluOut <= w_aluY;
               end
            end
            S_MEM: begin
               if (w_memDone && (w_op == OP_LW)) r_mdr <= mem_rdata;
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = w_memReq;
   assign mem_we    = (r_state == S_MEM) && (w_op == OP_SW);
   assign mem_addr  = (r_state == S_MEM) ? r_aluOut : r_pc;
   assign mem_wdata = r_b;
   assign retire    = !reset && (((r_state == S_EXEC) && ((w_op == OP_BEQ) || (w_op == OP_J))) ||
                                 ((r_state == S_MEM) && (w_op == OP_SW) && w_memDone) ||
                                 (r_state == S_WB));
   assign pc_out    = r_pc;
   assign halted    = (r_state == S_HALT);
   assign fault     = r_fault;

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed testbench for multicycle_processor with a unified memory model
// whose response latency can be set per test or stalled forever.
module tb_multicycle_processor;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
   logic [1:0]  fault;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] progMem [256];
   logic [31:0] dataMem [256];
   bit          dataValid [256];
   logic        memClear;
   int          latency;
   logic        stallForever;
   int          waitCnt = 0;
   int          retireAt [8];

   int expZero [5] = '{4, 8, 12, 16, 21};
   int expSlow [5] = '{7, 14, 21, 31, 42};

   always #5 clk = ~clk;

   multicycle_processor #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .retire    (retire),
      .pc_out    (pc_out),
      .halted    (halted),
      .fault     (fault)
   );

   // Memory model: program words come from progMem until a store overrides them
   assign mem_ready = mem_req && !stallForever && (waitCnt >= latency);
   assign mem_rdata = dataValid[mem_addr[9:2]] ? dataMem[mem_addr[9:2]] : progMem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_req && !mem_ready) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
      if (memClear) begin
         for (int i = 0; i < 256; i++) dataValid[i] <= 1'b0;
      end else if (mem_req && mem_ready && mem_we) begin
         dataMem[mem_addr[9:2]]   <= mem_wdata;
         dataValid[mem_addr[9:2]] <= 1'b1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Request fields must hold still across every stalled cycle
   logic        lastWait = 1'b0;
   logic        lastWe;
   logic [31:0] lastAddr, lastWdata;
   always @(negedge clk) begin
      if (lastWait && mem_req) begin
         checkOutput("addrStable", mem_addr, lastAddr);
         checkOutput("weStable", 32'(mem_we), 32'(lastWe));
         checkOutput("wdataStable", mem_wdata, lastWdata);
      end
      lastWait  = mem_req && !mem_ready;
      lastAddr  = mem_addr;
      lastWe    = mem_we;
      lastWdata = mem_wdata;
   end

   function automatic logic [31:0] memWord(input int idx);
      return dataValid[idx] ? dataMem[idx] : progMem[idx];
   endfunction

   function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic clearProg();
      for (int i = 0; i < 256; i++) progMem[i] = 32'd0;
   endtask

   task automatic loadMainProgram();
      clearProg();
      progMem[0] = encI(6'h08, 5'd0, 5'd1, 16'd5);
      progMem[1] = encI(6'h08, 5'd0, 5'd2, 16'd7);
      progMem[2] = encR(5'd1, 5'd2, 5'd3, 6'h20);
      progMem[3] = encI(6'h2b, 5'd0, 5'd3, 16'h0040);
      progMem[4] = encI(6'h23, 5'd0, 5'd4, 16'h0040);
   endtask

   // Hold reset for two edges, then release; returns inside the first FETCH cycle
   task automatic applyStimulus(input int lat, input logic stall);
      reset        = 1'b1;
      memClear     = 1'b1;
      latency      = lat;
      stallForever = stall;
      @(negedge clk);
      @(negedge clk);
      memClear = 1'b0;
      reset    = 1'b0;
      #1;
   endtask

   // Count cycles from the current one until n retire pulses; records the
   // cumulative cycle number of each pulse in retireAt
   task automatic runRetires(input int n, input int budget);
      int cyc = 0;
      int got = 0;
      while ((got < n) && (cyc < budget)) begin
         cyc++;
         if (retire) begin
            retireAt[got] = cyc;
            got++;
         end
         @(negedge clk);
      end
      checkOutput("retireCount", got, n);
   endtask

   initial begin
      int reqCount;
      int retCount;
      reset        = 1'b1;
      memClear     = 1'b1;
      latency      = 0;
      stallForever = 1'b0;

      // Reset state and first fetch
      loadMainProgram();
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstReq", 32'(mem_req), 32'd0);
      checkOutput("rstRetire", 32'(retire), 32'd0);
      checkOutput("rstHalted", 32'(halted), 32'd0);
      checkOutput("rstFault", 32'(fault), 32'd0);
      checkOutput("rstPc", pc_out, 32'h0);
      memClear = 1'b0;
      reset    = 1'b0;
      #1;
      checkOutput("firstReq", 32'(mem_req), 32'd1);
      checkOutput("firstAddr", mem_addr, 32'h0);
      checkOutput("firstWe", 32'(mem_we), 32'd0);

      // Main program, zero-wait memory
      runRetires(5, 100);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("zeroLat%0d", i), retireAt[i], expZero[i]);
      checkOutput("zeroR3", dut.uRegfile.r_regs[3], 32'd12);
      checkOutput("zeroR4", dut.uRegfile.r_regs[4], 32'd12);
      checkOutput("zeroMem40", memWord(16), 32'd12);
      checkOutput("zeroPc", pc_out, 32'h14);

      // Same program, three wait states on every request
      loadMainProgram();
      applyStimulus(3, 1'b0);
      runRetires(5, 200);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("slowLat%0d", i), retireAt[i], expSlow[i]);
      checkOutput("slowR3", dut.uRegfile.r_regs[3], 32'd12);
      checkOutput("slowR4", dut.uRegfile.r_regs[4], 32'd12);
      checkOutput("slowMem40", memWord(16), 32'd12);

      // beq taken at 0x10 -> 0x1C
      clearProg();
      progMem[0] = encI(6'h08, 5'd0, 5'd1, 16'd3);
      progMem[1] = encI(6'h08, 5'd0, 5'd2, 16'd4);
      progMem[2] = encI(6'h08, 5'd1, 5'd1, 16'd0);
      progMem[3] = encI(6'h08, 5'd2, 5'd2, 16'd0);
      progMem[4] = encI(6'h04, 5'd1, 5'd1, 16'd2);
      applyStimulus(0, 1'b0);
      runRetires(5, 100);
      checkOutput("beqTakenLat", retireAt[4] - retireAt[3], 32'd3);
      checkOutput("beqTakenPc", pc_out, 32'h1C);

      // beq not taken at 0x10 -> 0x14, then j 0x100 -> 0x400
      progMem[4] = encI(6'h04, 5'd1, 5'd2, 16'd2);
      progMem[5] = {6'h02, 26'h100};
      applyStimulus(0, 1'b0);
      runRetires(5, 100);
      checkOutput("beqNotTakenLat", retireAt[4] - retireAt[3], 32'd3);
      checkOutput("beqNotTakenPc", pc_out, 32'h14);
      runRetires(1, 20);
      checkOutput("jumpLat", retireAt[0], 32'd3);
      checkOutput("jumpPc", pc_out, 32'h400);

      // Misaligned lw from 0x42: halt, no data request, destination untouched
      clearProg();
      progMem[0] = encI(6'h08, 5'd0, 5'd4, 16'd9);
      progMem[1] = encI(6'h23, 5'd0, 5'd4, 16'h0042);
      applyStimulus(0, 1'b0);
      runRetires(1, 20);
      checkOutput("misFetchAddr", mem_addr, 32'h4);
      reqCount = 0;
      retCount = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mem_req) reqCount++;
         if (retire) retCount++;
      end
      checkOutput("misReqCount", reqCount, 32'd0);
      checkOutput("misRetireCount", retCount, 32'd0);
      checkOutput("misHalted", 32'(halted), 32'd1);
      checkOutput("misFault", 32'(fault), 32'd2);
      checkOutput("misPc", pc_out, 32'h8);
      checkOutput("misR4", dut.uRegfile.r_regs[4], 32'd9);
      applyStimulus(0, 1'b0);
      checkOutput("misResetHalted", 32'(halted), 32'd0);
      checkOutput("misResetFault", 32'(fault), 32'd0);
      checkOutput("misResetReq", 32'(mem_req), 32'd1);
      checkOutput("misResetAddr", mem_addr, 32'h0);

      // Memory never ready: request drops after 16 wait cycles
      applyStimulus(0, 1'b1);
      reqCount = 0;
      for (int k = 0; k < 40; k++) begin
         if (mem_req) reqCount++;
         @(negedge clk);
      end
      checkOutput("toReqCycles", reqCount, 32'd16);
      checkOutput("toFault", 32'(fault), 32'd3);
      checkOutput("toHalted", 32'(halted), 32'd1);

      // Illegal opcode 0x3F halts right after DECODE
      clearProg();
      progMem[0] = {6'h3f, 26'd0};
      applyStimulus(0, 1'b0);
      checkOutput("illFetchReq", 32'(mem_req), 32'd1);
      @(negedge clk);
      checkOutput("illDecodeHalted", 32'(halted), 32'd0);
      checkOutput("illDecodeReq", 32'(mem_req), 32'd0);
      @(negedge clk);
      checkOutput("illHalted", 32'(halted), 32'd1);
      checkOutput("illFault", 32'(fault), 32'd1);
      checkOutput("illRetire", 32'(retire), 32'd0);
      checkOutput("illPc", pc_out, 32'h4);

      // Reset in the middle of a stalled lw MEM access
      clearProg();
      progMem[0]  = encI(6'h08, 5'd0, 5'd1, 16'd5);
      progMem[1]  = encI(6'h23, 5'd0, 5'd4, 16'h0040);
      progMem[16] = 32'd77;
      applyStimulus(3, 1'b0);
      runRetires(1, 30);
      checkOutput("rmAddiLat", retireAt[0], 32'd7);
      for (int k = 0; k < 6; k++) @(negedge clk);
      checkOutput("rmMemReq", 32'(mem_req), 32'd1);
      checkOutput("rmMemAddr", mem_addr, 32'h40);
      checkOutput("rmMemWe", 32'(mem_we), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rmReqGated", 32'(mem_req), 32'd0);
      clearProg();
      progMem[0]  = encI(6'h08, 5'd0, 5'd1, 16'd5);
      progMem[1]  = encR(5'd1, 5'd1, 5'd0, 6'h20);
      progMem[2]  = encI(6'h2b, 5'd0, 5'd0, 16'h0048);
      progMem[18] = 32'hdead_beef;
      applyStimulus(0, 1'b0);
      checkOutput("rmR1Cleared", dut.uRegfile.r_regs[1], 32'd0);
      checkOutput("rmPc", pc_out, 32'h0);
      checkOutput("rmRefetchReq", 32'(mem_req), 32'd1);
      checkOutput("rmRefetchAddr", mem_addr, 32'h0);
      runRetires(3, 50);
      checkOutput("r0StoreLat", retireAt[2], 32'd12);
      checkOutput("r0Stored", memWord(18), 32'd0);
      checkOutput("r0R1", dut.uRegfile.r_regs[1], 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
